// File: rtl/edge_mem_ctrl.sv
// Edge memory sequencer: streams an edge list into BRAM, then arbitrates the
// single read port round-robin across NREQ engines and routes responses back.
module edge_mem_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 36,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_load,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   ld_last,
  output logic                   load_done,
  output logic [ADDR_W:0]        edge_count,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   mem_wren,
  output logic [ADDR_W-1:0]      mem_wraddr,
  output logic [DATA_W-1:0]      mem_wrdata,
  output logic [ADDR_W-1:0]      mem_rdaddr,
  input  logic [DATA_W-1:0]      mem_q
);

  localparam int unsigned     PTR_W     = $clog2(NREQ);
  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t                      r_state, w_next;
  logic [ADDR_W:0]             r_count;
  logic                        r_load_done;
  logic                        r_wren;
  logic [ADDR_W-1:0]           r_wraddr, r_rdaddr;
  logic [DATA_W-1:0]           r_wrdata;
  logic [PTR_W-1:0]            r_rr_ptr;
  logic [RD_LAT:0]             r_pv, r_poob;
  logic [RD_LAT:0][NREQ-1:0]   r_pid;

  logic                        w_ld_ready, w_run_ok, w_ld_hs, w_ld_end;
  logic                        w_gnt_vld, w_grant, w_gnt_oob, w_pipe_busy;
  logic [PTR_W-1:0]            w_gnt_idx;
  logic [NREQ-1:0]             w_req_ready;
  logic [ADDR_W-1:0]           w_gnt_addr;
  int unsigned                 w_idx;

  assign w_ld_hs     = w_ld_ready & ld_valid;
  assign w_ld_end    = w_ld_hs & (ld_last | (r_count == LAST_SLOT));
  assign w_pipe_busy = |r_pv;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_load)   w_next = S_LOAD;
      S_LOAD:  if (w_ld_end)     w_next = S_RUN;
      S_RUN:   if (start_load)   w_next = S_DRAIN;
      S_DRAIN: if (!w_pipe_busy) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; held low during reset so nothing is accepted then
  always_comb begin
    w_ld_ready = 1'b0;
    w_run_ok   = 1'b0;
    unique case (r_state)
      S_LOAD:  w_ld_ready = !r_count[ADDR_W] && !rst;
      S_RUN:   w_run_ok   = !start_load && !rst;
      default: ;
    endcase
  end

  // Round-robin search starting one past the last granted requester
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % NREQ;
      if (!w_gnt_vld && req_valid[PTR_W'(w_idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PTR_W'(w_idx);
      end
    end
  end

  assign w_grant    = w_gnt_vld & w_run_ok;
  assign w_gnt_addr = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_gnt_oob  = ({1'b0, w_gnt_addr} >= r_count);

  always_comb begin
    w_req_ready = '0;
    if (w_grant) w_req_ready[w_gnt_idx] = 1'b1;
  end

  // Load/write datapath, read address and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_load_done <= 1'b0;
      r_wren      <= 1'b0;
      r_wraddr    <= '0;
      r_wrdata    <= '0;
      r_rdaddr    <= '0;
      r_rr_ptr    <= PTR_W'(NREQ - 1);
    end else begin
      r_wren      <= w_ld_hs;
      r_load_done <= w_ld_end;
      if (w_ld_hs) begin
        r_wraddr <= r_count[ADDR_W-1:0];
        r_wrdata <= ld_data;
        r_count  <= r_count + CNT_ONE;
      end else if (w_next == S_LOAD && r_state != S_LOAD) begin
        r_count <= '0;
      end
      if (w_grant) begin
        r_rdaddr <= w_gnt_addr;
        r_rr_ptr <= w_gnt_idx;
      end
    end
  end

  // Response tracker: stage k holds the grant issued k+1 cycles earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv   <= '0;
      r_poob <= '0;
      r_pid  <= '0;
    end else begin
      r_pv   <= {r_pv[RD_LAT-1:0], w_grant};
      r_poob <= {r_poob[RD_LAT-1:0], w_gnt_oob};
      r_pid  <= {r_pid[RD_LAT-1:0], w_req_ready};
    end
  end

  assign ld_ready   = w_ld_ready;
  assign req_ready  = w_req_ready;
  assign load_done  = r_load_done;
  assign edge_count = r_count;
  assign mem_wren   = r_wren;
  assign mem_wraddr = r_wraddr;
  assign mem_wrdata = r_wrdata;
  assign mem_rdaddr = r_rdaddr;
  assign rsp_valid  = (r_pv[RD_LAT] && !rst) ? r_pid[RD_LAT] : '0;
  assign rsp_data   = (r_pv[RD_LAT] && !r_poob[RD_LAT] && !rst) ? mem_q : '0;

endmodule

// File: doc/edge_mem_ctrl.md
# edge_mem_ctrl

Sequencer and read arbiter for the graph edge memory, a simple dual-port BRAM with a single write port and a single read port. The block runs in two phases. In the load phase it accepts a streamed edge list and writes it to consecutive addresses from 0. In the run phase it shares the single read port among `NREQ` processing engines with round-robin arbitration and routes each read response back to its requester. It sits between the DMA/loader stream, the edge BRAM and the engine array.

## Interface
- `ADDR_W`, 10, edge memory address width.
- `DATA_W`, 36, edge word width.
- `NREQ`, 4, number of read requesters (2..8).
- `RD_LAT`, 2, BRAM read latency in cycles, from `mem_rdaddr` to `mem_q` (≥1).

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start_load` in 1: pulse that begins a (re)load.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in `DATA_W`, `ld_last` in 1: load stream.
- `load_done` out 1: one-cycle pulse when the load phase ends.
- `edge_count` out `ADDR_W+1`: number of edges stored.
- `req_valid` in `NREQ`, `req_ready` out `NREQ`, `req_addr` in `NREQ*ADDR_W`: per-engine read requests; engine i uses slice `[i*ADDR_W +: ADDR_W]`.
- `rsp_valid` out `NREQ`: one-hot, marks the requester a response belongs to.
- `rsp_data` out `DATA_W`: response data.
- `mem_wren` out 1, `mem_wraddr` out `ADDR_W`, `mem_wrdata` out `DATA_W`: BRAM write port.
- `mem_rdaddr` out `ADDR_W`, `mem_q` in `DATA_W`: BRAM read port.

## Operation
- **States:** IDLE, LOAD, RUN, DRAIN.
- **IDLE**
  - `start_load` moves to LOAD.
  - All `req_ready` and `ld_ready` are 0.
- **LOAD**
  - `ld_ready`=1 while `edge_count` < 2^`ADDR_W`.
  - Each handshake writes `ld_data` at address `edge_count`, then increments `edge_count`.
  - The handshake with `ld_last`=1, or the handshake that brings `edge_count` to 2^`ADDR_W`, moves to RUN and pulses `load_done`.
  - On that transition `ld_ready` drops to 0 immediately. Further beats are not accepted.
  - `start_load` is ignored in LOAD.
- **RUN**
  - At most one grant per cycle, by round robin.
  - The search starts at (last granted + 1) mod `NREQ`. The pointer resets to `NREQ`-1, so requester 0 has first priority after reset.
  - `req_ready[i]` is combinational and asserted only for the granted i, and only if `req_valid[i]`.
  - A granted address ≥ `edge_count` is still issued to the BRAM. Its response is returned with `rsp_data`=0 (out-of-range read).
  - `start_load` moves to DRAIN. No grant is made in that cycle.
- **DRAIN**
  - No grants are made.
  - Stay in DRAIN until all in-flight reads have returned. Then go to LOAD with `edge_count` cleared to 0.
  - No read may overlap a rewrite.
- **Response tracking:** a shift pipeline of (valid, one-hot id, oob) with depth 1+`RD_LAT`. At its output, `rsp_valid` = id when valid, and `rsp_data` = `mem_q` (or 0 if oob).
- **`rsp_data` idle value:** 0 whenever no `rsp_valid` bit is set.

## Timing
- **Write latency:** a load handshake in cycle t drives registered `mem_wren`/`mem_wraddr`/`mem_wrdata` in cycle t+1.
- **Read latency:** a grant in cycle t gives registered `mem_rdaddr` in t+1 and `rsp_valid` in t+1+`RD_LAT`.
- **Throughput:** one grant and one response per cycle in steady state, with no bubbles.
- **LOAD→RUN:** if the final write is in cycle t+1, the earliest grant is t+1 and its read address lands at t+2. Read-after-write is therefore always safe.
- **DRAIN length:** exactly 1+`RD_LAT` cycles if a grant occurred in the cycle before entry. Otherwise DRAIN may exit early once the pipeline is empty.
- **Reset values:** state IDLE; `edge_count`, `ld_ready`, `load_done`, `req_ready`, `rsp_valid`, `rsp_data`, `mem_wren`, `mem_wraddr`, `mem_wrdata`, `mem_rdaddr` all 0; round-robin pointer `NREQ`-1.
- **Reset mid-operation:** in-flight responses are dropped. No `rsp_valid` appears after reset is asserted, and the state returns to IDLE.

## Test plan
- **Load:** `start_load`, then 5 beats with data 0x100..0x104, `ld_last` on the 5th. Expect:
  - `mem_wraddr` 0..4, one cycle after each beat.
  - `load_done` pulse.
  - `edge_count`=5.
- **Round robin:** in RUN, all 4 requesters hold `req_valid` with addr=i. Expect:
  - Grants in order 0,1,2,3,0,…
  - `rsp_valid` one-hot in the same order, 1+`RD_LAT` cycles after each grant.
  - `rsp_data` = the data stored at addr i.
- **Out-of-range:** with `edge_count`=5, requester 2 reads addr 7. Expect `rsp_valid`=0b0100 with `rsp_data`=0.
- **Overflow:** `ADDR_W`=3, stream 10 beats with no `ld_last`. Expect:
  - 8 writes.
  - `ld_ready` low after the 8th beat.
  - `load_done` pulse.
  - `edge_count`=8.
- **Reload during traffic:** `start_load` in RUN with grants in flight. Expect:
  - All in-flight responses delivered.
  - No grants during DRAIN.
  - LOAD entered with `edge_count`=0.
  - No write before the last response returns.
- **Mid-read reset:** assert `rst` 1 cycle after a grant. Expect no `rsp_valid`, and all outputs at their reset values.
